// File: rtl/imem_program_loader_if.sv
// Loader bus bundle: host byte stream (valid/ready) plus the instruction-memory write port.
interface imem_program_loader_if #(
   parameter int ADDR_WIDTH = 8
);
   logic                  in_valid;
   logic [7:0]            in_data;
   logic                  in_ready;
   logic                  imem_we;
   logic [ADDR_WIDTH-1:0] imem_addr;
   logic [31:0]           imem_wdata;

   modport master (
      output in_valid, in_data,
      input  in_ready, imem_we, imem_addr, imem_wdata
   );

   modport slave (
      input  in_valid, in_data,
      output in_ready, imem_we, imem_addr, imem_wdata
   );
endinterface

// File: rtl/imem_program_loader.sv
// Length-prefixed little-endian byte stream -> 32-bit instruction-memory writes; holds the core in reset while loading.
// Optional trailing XOR checksum byte enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_program_loader #(
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   imem_program_loader_if.slave  bus,
   output logic                  cpu_reset,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic [15:0]           word_count
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR0,
      S_HDR1,
      S_DATA,
      S_WRITE,
      S_RUN,
      S_ERR
`ifdef IMEM_LOADER_CHECKSUM_EN
      , S_CSUM
`endif
   } state_t;

   localparam logic [16:0] CAPACITY = 17'(1) << ADDR_WIDTH;

   state_t                state_q, state_d;
   logic [15:0]           count_q, count_d;
   logic [ADDR_WIDTH-1:0] widx_q, widx_d;
   logic [1:0]            bidx_q, bidx_d;
   logic [31:0]           word_q, word_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]            csum_q, csum_d;
`endif

   logic [15:0] hdr_count;
   logic        last_word;

   assign hdr_count  = {bus.in_data, count_q[7:0]};
   assign last_word  = (16'(widx_q) == (count_q - 16'd1));
   assign word_count = count_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         count_q <= '0;
         widx_q  <= '0;
         bidx_q  <= '0;
         word_q  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         csum_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         widx_q  <= widx_d;
         bidx_q  <= bidx_d;
         word_q  <= word_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
         csum_q  <= csum_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      widx_d  = widx_q;
      bidx_d  = bidx_q;
      word_d  = word_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_d  = csum_q;
`endif
      case (state_q)
         S_IDLE, S_RUN, S_ERR: begin
            if (start) begin
               state_d = S_HDR0;
               count_d = '0;
               widx_d  = '0;
               bidx_d  = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
               csum_d  = '0;
`endif
            end
         end
         S_HDR0: begin
            if (bus.in_valid) begin
               count_d[7:0] = bus.in_data;
               state_d      = S_HDR1;
            end
         end
         S_HDR1: begin
            if (bus.in_valid) begin
               count_d[15:8] = bus.in_data;
               widx_d        = '0;
               bidx_d        = '0;
               if (hdr_count == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                  state_d = S_CSUM;
`else
                  state_d = S_RUN;
`endif
               end else if ({1'b0, hdr_count} > CAPACITY) begin
                  state_d = S_ERR;
               end else begin
                  state_d = S_DATA;
               end
            end
         end
         S_DATA: begin
            if (bus.in_valid) begin
               word_d[{bidx_q, 3'b000} +: 8] = bus.in_data;
               bidx_d = bidx_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
               csum_d = csum_q ^ bus.in_data;
`endif
               if (bidx_q == 2'd3) state_d = S_WRITE;
            end
         end
         S_WRITE: begin
            if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
               state_d = S_CSUM;
`else
               state_d = S_RUN;
`endif
            end else begin
               widx_d  = widx_q + 1'b1;
               state_d = S_DATA;
            end
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         S_CSUM: begin
            if (bus.in_valid) state_d = (bus.in_data == csum_q) ? S_RUN : S_ERR;
         end
`endif
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      bus.in_ready   = 1'b0;
      bus.imem_we    = 1'b0;
      bus.imem_addr  = '0;
      bus.imem_wdata = '0;
      cpu_reset      = 1'b1;
      busy           = 1'b0;
      done           = 1'b0;
      error          = 1'b0;
      case (state_q)
         S_HDR0, S_HDR1, S_DATA: begin
            bus.in_ready = 1'b1;
            busy         = 1'b1;
         end
         S_WRITE: begin
            busy           = 1'b1;
            bus.imem_we    = 1'b1;
            bus.imem_addr  = widx_q;
            bus.imem_wdata = word_q;
         end
         S_RUN: begin
            cpu_reset = 1'b0;
            done      = 1'b1;
         end
         S_ERR: error = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
         S_CSUM: begin
            bus.in_ready = 1'b1;
            busy         = 1'b1;
         end
`endif
         default: ;
      endcase
   end

endmodule

// File: tb/tb_imem_program_loader.sv
// Directed bench for imem_program_loader: loads, stalls, count bounds, reload, checksum, abort.
module tb_imem_program_loader;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        cpu_reset, busy, done, error;
   logic [15:0] word_count;

   imem_program_loader_if #(.ADDR_WIDTH(8)) bus ();

   imem_program_loader #(.ADDR_WIDTH(8)) dut (
      .clk        (clk),
      .reset      (rst_n),
      .start      (start),
      .bus        (bus),
      .cpu_reset  (cpu_reset),
      .busy       (busy),
      .done       (done),
      .error      (error),
      .word_count (word_count)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;
   int nwr   = 0;
   logic [7:0]  wa [0:1023];
   logic [31:0] wd [0:1023];
   int          wc [0:1023];
   logic [7:0]  xacc;

   always @(posedge clk) cyc <= cyc + 1;

   // write log, sampled mid-cycle while the strobe is stable
   always @(negedge clk) begin
      if (bus.imem_we === 1'b1 && nwr < 1024) begin
         wa[nwr] = bus.imem_addr;
         wd[nwr] = bus.imem_wdata;
         wc[nwr] = cyc;
         nwr     = nwr + 1;
      end
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached (tests=%0d)", tests);
      $fatal(1);
   end

   task automatic do_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      xacc  = 8'h00;
   endtask

   task automatic send_byte(input logic [7:0] b, input bit is_data);
      int n;
      bus.in_valid = 1'b1;
      bus.in_data  = b;
      n = 0;
      while (bus.in_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) begin
         tests++;
         fails++;
         $display("FAIL send_timeout: in_ready=%b required 1 for byte %h", bus.in_ready, b);
      end
      @(negedge clk);
      if (is_data) xacc = xacc ^ b;
   endtask

   task automatic send_trailer();
`ifdef IMEM_LOADER_CHECKSUM_EN
      send_byte(xacc, 1'b0);
`endif
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_done();
      for (int n = 0; n < 20 && done !== 1'b1 && error !== 1'b1; n++) @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;
      #12;
      tests++; if ({cpu_reset, bus.in_ready, bus.imem_we, done, error, busy} !== 6'b100000) begin
         fails++; $display("FAIL reset_outputs: got %b required 100000", {cpu_reset, bus.in_ready, bus.imem_we, done, error, busy});
      end
      tests++; if (word_count !== 16'h0000) begin
         fails++; $display("FAIL reset_word_count: got %h required 0000", word_count);
      end
      @(negedge clk);
      rst_n = 1'b1;
      bus.in_valid = 1'b1;
      repeat (3) @(negedge clk);
      bus.in_valid = 1'b0;
      tests++; if ({cpu_reset, bus.in_ready, bus.imem_we, done, error, busy} !== 6'b100000 || nwr !== 0) begin
         fails++; $display("FAIL idle_hold: got %b nwr=%0d required 100000 nwr=0", {cpu_reset, bus.in_ready, bus.imem_we, done, error, busy}, nwr);
      end
   endtask

   task automatic test_load5();
      logic [7:0]  s [0:19];
      logic [31:0] ew [0:4];
      int base, bad;
      s = '{8'h93,8'h00,8'h10,8'h00, 8'h13,8'h01,8'h80,8'h00, 8'h13,8'h02,8'hA0,8'h00,
            8'h93,8'h01,8'h00,8'h00, 8'hB3,8'h81,8'h20,8'h00};
      ew = '{32'h00100093, 32'h00800113, 32'h00A00213, 32'h00000193, 32'h002081B3};
      base = nwr;
      do_start();
      tests++; if (busy !== 1'b1 || bus.in_ready !== 1'b1 || cpu_reset !== 1'b1) begin
         fails++; $display("FAIL load5_hdr0: busy=%b ready=%b cpu_reset=%b required 1 1 1", busy, bus.in_ready, cpu_reset);
      end
      send_byte(8'h05, 1'b0);
      send_byte(8'h00, 1'b0);
      for (int i = 0; i < 20; i++) send_byte(s[i], 1'b1);
      send_trailer();
      wait_done();
      tests++; if (nwr - base !== 5) begin
         fails++; $display("FAIL load5_count: got %0d writes required 5", nwr - base);
      end
      bad = 0;
      for (int i = 0; i < 5; i++) if (wa[base+i] !== 8'(i) || wd[base+i] !== ew[i]) bad++;
      tests++; if (bad !== 0) begin
         fails++; $display("FAIL load5_data: got %0d bad words (first %h@%h) required 0", bad, wd[base], wa[base]);
      end
      bad = 0;
      for (int i = 1; i < 5; i++) if (wc[base+i] - wc[base+i-1] !== 5) bad++;
      tests++; if (bad !== 0) begin
         fails++; $display("FAIL load5_spacing: got %0d gaps not equal to 5 required 0", bad);
      end
`ifndef IMEM_LOADER_CHECKSUM_EN
      tests++; if (cyc !== wc[base+4] + 1) begin
         fails++; $display("FAIL load5_release_cycle: done at cycle %0d required %0d", cyc, wc[base+4] + 1);
      end
      tests++; if (bus.in_ready !== 1'b0) begin
         fails++; $display("FAIL run_no_trailer: in_ready=%b required 0", bus.in_ready);
      end
`endif
      tests++; if (done !== 1'b1 || cpu_reset !== 1'b0 || word_count !== 16'd5) begin
         fails++; $display("FAIL load5_run: done=%b cpu_reset=%b wc=%0d required 1 0 5", done, cpu_reset, word_count);
      end
   endtask

   task automatic test_stall();
      logic [7:0] s [0:5];
      int base;
      s = '{8'h01, 8'h00, 8'h13, 8'h01, 8'h80, 8'h00};
      base = nwr;
      do_start();
      tests++; if (cpu_reset !== 1'b1 || done !== 1'b0 || word_count !== 16'h0000 || busy !== 1'b1) begin
         fails++; $display("FAIL restart_edge: cpu_reset=%b done=%b wc=%h busy=%b required 1 0 0000 1", cpu_reset, done, word_count, busy);
      end
      for (int i = 0; i < 6; i++) begin
         send_byte(s[i], i >= 2);
         bus.in_valid = 1'b0;
         if (i == 3) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            repeat (2) @(negedge clk);
         end else if (i < 5) begin
            repeat (3) @(negedge clk);
         end
      end
      send_trailer();
      wait_done();
      repeat (3) @(negedge clk);
      tests++; if (nwr - base !== 1 || wa[base] !== 8'h00 || wd[base] !== 32'h00800113) begin
         fails++; $display("FAIL stall_write: got n=%0d %h@%h required n=1 00800113@00", nwr - base, wd[base], wa[base]);
      end
      tests++; if (done !== 1'b1 || cpu_reset !== 1'b0) begin
         fails++; $display("FAIL stall_run: done=%b cpu_reset=%b required 1 0", done, cpu_reset);
      end
   endtask

   task automatic test_reload();
      int base;
      base = nwr;
      do_start();
      tests++; if (cpu_reset !== 1'b1 || done !== 1'b0) begin
         fails++; $display("FAIL reload_edge: cpu_reset=%b done=%b required 1 0", cpu_reset, done);
      end
      send_byte(8'h01, 1'b0);
      send_byte(8'h00, 1'b0);
      send_byte(8'h93, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'hF0, 1'b1);
      send_byte(8'h0F, 1'b1);
      send_trailer();
      wait_done();
      tests++; if (nwr - base !== 1 || wa[base] !== 8'h00 || wd[base] !== 32'h0FF00093 || done !== 1'b1) begin
         fails++; $display("FAIL reload_write: got n=%0d %h@%h done=%b required n=1 0FF00093@00 done=1", nwr - base, wd[base], wa[base], done);
      end
   endtask

   task automatic test_bounds();
      int base, bad;
      base = nwr;
      do_start();
      send_byte(8'h01, 1'b0);
      send_byte(8'h01, 1'b0);
      bus.in_valid = 1'b0;
      repeat (3) @(negedge clk);
      tests++; if (error !== 1'b1 || cpu_reset !== 1'b1 || done !== 1'b0 || nwr - base !== 0 || word_count !== 16'h0101) begin
         fails++; $display("FAIL count_257: error=%b cpu_reset=%b done=%b n=%0d wc=%h required 1 1 0 0 0101", error, cpu_reset, done, nwr - base, word_count);
      end
      base = nwr;
      do_start();
      tests++; if (error !== 1'b0 || busy !== 1'b1) begin
         fails++; $display("FAIL restart_from_err: error=%b busy=%b required 0 1", error, busy);
      end
      send_byte(8'h00, 1'b0);
      send_byte(8'h01, 1'b0);
      for (int w = 0; w < 256; w++) begin
         send_byte(8'h5A, 1'b1);
         send_byte(8'(w), 1'b1);
         send_byte(~8'(w), 1'b1);
         send_byte(8'(w), 1'b1);
      end
      send_trailer();
      wait_done();
      bad = 0;
      for (int w = 0; w < 256; w++)
         if (wa[base+w] !== 8'(w) || wd[base+w] !== {8'(w), ~8'(w), 8'(w), 8'h5A}) bad++;
      tests++; if (nwr - base !== 256 || bad !== 0 || done !== 1'b1) begin
         fails++; $display("FAIL count_256: n=%0d bad=%0d done=%b required 256 0 1", nwr - base, bad, done);
      end
      base = nwr;
      do_start();
      send_byte(8'h00, 1'b0);
      send_byte(8'h00, 1'b0);
      send_trailer();
      wait_done();
      tests++; if (done !== 1'b1 || cpu_reset !== 1'b0 || error !== 1'b0 || nwr - base !== 0) begin
         fails++; $display("FAIL count_0: done=%b cpu_reset=%b error=%b n=%0d required 1 0 0 0", done, cpu_reset, error, nwr - base);
      end
   endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
   task automatic test_checksum();
      do_start();
      send_byte(8'h01, 1'b0);
      send_byte(8'h00, 1'b0);
      send_byte(8'h93, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h10, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h83, 1'b0);
      bus.in_valid = 1'b0;
      wait_done();
      tests++; if (done !== 1'b1 || error !== 1'b0) begin
         fails++; $display("FAIL csum_good: done=%b error=%b required 1 0", done, error);
      end
      do_start();
      send_byte(8'h01, 1'b0);
      send_byte(8'h00, 1'b0);
      send_byte(8'h93, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h10, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h84, 1'b0);
      bus.in_valid = 1'b0;
      wait_done();
      tests++; if (error !== 1'b1 || done !== 1'b0 || cpu_reset !== 1'b1) begin
         fails++; $display("FAIL csum_bad: error=%b done=%b cpu_reset=%b required 1 0 1", error, done, cpu_reset);
      end
   endtask
`endif

   task automatic test_abort();
      int base;
      base = nwr;
      do_start();
      send_byte(8'h02, 1'b0);
      send_byte(8'h00, 1'b0);
      send_byte(8'h11, 1'b1);
      send_byte(8'h22, 1'b1);
      rst_n = 1'b0;
      #1;
      tests++; if (busy !== 1'b0 || bus.in_ready !== 1'b0 || cpu_reset !== 1'b1 || word_count !== 16'h0000) begin
         fails++; $display("FAIL abort_async: busy=%b ready=%b cpu_reset=%b wc=%h required 0 0 1 0000", busy, bus.in_ready, cpu_reset, word_count);
      end
      bus.in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      tests++; if (nwr - base !== 0 || busy !== 1'b0 || done !== 1'b0) begin
         fails++; $display("FAIL abort_idle: n=%0d busy=%b done=%b required 0 0 0", nwr - base, busy, done);
      end
      do_start();
      send_byte(8'h01, 1'b0);
      send_byte(8'h00, 1'b0);
      send_byte(8'h13, 1'b1);
      send_byte(8'h01, 1'b1);
      send_byte(8'h80, 1'b1);
      send_byte(8'h00, 1'b1);
      send_trailer();
      wait_done();
      tests++; if (nwr - base !== 1 || wa[base] !== 8'h00 || wd[base] !== 32'h00800113 || done !== 1'b1) begin
         fails++; $display("FAIL abort_reload: n=%0d %h@%h done=%b required 1 00800113@00 1", nwr - base, wd[base], wa[base], done);
      end
   endtask

   initial begin
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;
      xacc = 8'h00;
      test_reset();
      test_load5();
      test_stall();
      test_reload();
      test_bounds();
`ifdef IMEM_LOADER_CHECKSUM_EN
      test_checksum();
`endif
      test_abort();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
